// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    localparam int HAZ_REG_AW = 5;
    localparam int X0         = 0;
    localparam int PERF_W     = 32;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
    parameter int REG_AW = hazard_pkg::HAZ_REG_AW
);
    logic              idex_memread;
    logic [REG_AW-1:0] idex_rd;
    logic [REG_AW-1:0] ifid_rs1;
    logic [REG_AW-1:0] ifid_rs2;
    logic              ifid_uses_rs2;
    logic              branch_taken;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    logic              stall_active;

    modport master (
        output idex_memread, idex_rd, ifid_rs1, ifid_rs2,
        output ifid_uses_rs2, branch_taken,
        input  pc_write, ifid_write, idex_bubble,
        input  ifid_flush, idex_flush, exmem_flush, stall_active
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs1, ifid_rs2,
        input  ifid_uses_rs2, branch_taken,
        output pc_write, ifid_write, idex_bubble,
        output ifid_flush, idex_flush, exmem_flush, stall_active
    );
endinterface

// File: rtl/lu_hazard_detect.sv
// Load-use comparator: ID/EX load destination vs IF/ID sources.
module lu_hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = HAZ_REG_AW
) (
    input  logic              memread,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              uses_rs2,
    output logic              hazard
);
    logic rd_nz;

    assign rd_nz  = (rd != REG_AW'(X0));
    assign hazard = memread & rd_nz &
                    ((rd == rs1) | (uses_rs2 & (rd == rs2)));
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/bubble/flush control for the ID/EX register.
// Define HAZ_PERF_CNT_EN to add stall_cnt/flush_cnt counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = HAZ_REG_AW,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef HAZ_PERF_CNT_EN
    output logic [PERF_W-1:0]   stall_cnt,
    output logic [PERF_W-1:0]   flush_cnt,
`endif
    hazard_ctrl_if.slave        hz
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             stall_q;
    logic             lu_hazard;
    logic             pc_w, ifid_w, bubble, flush;

    lu_hazard_detect #(.REG_AW(REG_AW)) u_det (
        .memread  (hz.idex_memread),
        .rd       (hz.idex_rd),
        .rs1      (hz.ifid_rs1),
        .rs2      (hz.ifid_rs2),
        .uses_rs2 (hz.ifid_uses_rs2),
        .hazard   (lu_hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= '0;
            stall_q <= 1'b0;
        end else if (hz.branch_taken) begin
            state   <= RUN;
            cnt     <= '0;
            stall_q <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (lu_hazard && (STALL_CYCLES > 1)) begin
                        state   <= LU_STALL;
                        cnt     <= CNT_INIT;
                        stall_q <= 1'b1;
                    end
                end
                LU_STALL: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state   <= RUN;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // Branch squashes everything; a stall in flight or a new hazard bubbles.
    always_comb begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (!reset) begin
            priority case (1'b1)
                hz.branch_taken: begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                    flush  = 1'b1;
                end
                (state == LU_STALL),
                lu_hazard: bubble = 1'b1;
                default: begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                end
            endcase
        end
    end

    assign hz.pc_write     = pc_w;
    assign hz.ifid_write   = ifid_w;
    assign hz.idex_bubble  = bubble;
    assign hz.ifid_flush   = flush;
    assign hz.idex_flush   = flush;
    assign hz.exmem_flush  = flush;
    assign hz.stall_active = stall_q;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_w && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (hz.branch_taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: three DUTs (STALL_CYCLES 1/3/4) on shared stimulus.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    typedef struct {
        logic [6:0] e [3];
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic       memread = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic       uses2 = 0, br = 0;

    int checks = 0;
    int errors = 0;
    int rem [3] = '{0, 0, 0};
    int scyc [3] = '{1, 3, 4};
    exp_t q [$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hz1 ();
    hazard_ctrl_if #(.REG_AW(5)) hz3 ();
    hazard_ctrl_if #(.REG_AW(5)) hz4 ();

`define HZ_DRIVE(H) \
    assign H.idex_memread = memread; \
    assign H.idex_rd = rd; \
    assign H.ifid_rs1 = rs1; \
    assign H.ifid_rs2 = rs2; \
    assign H.ifid_uses_rs2 = uses2; \
    assign H.branch_taken = br;

    `HZ_DRIVE(hz1)
    `HZ_DRIVE(hz3)
    `HZ_DRIVE(hz4)

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc [3];
    logic [31:0] fc [3];
    logic [31:0] msc [3] = '{0, 0, 0};
    logic [31:0] mfc [3] = '{0, 0, 0};
    hazard_ctrl_unit #(.STALL_CYCLES(1)) d1 (.clk(clk), .reset(reset),
        .stall_cnt(sc[0]), .flush_cnt(fc[0]), .hz(hz1));
    hazard_ctrl_unit #(.STALL_CYCLES(3)) d3 (.clk(clk), .reset(reset),
        .stall_cnt(sc[1]), .flush_cnt(fc[1]), .hz(hz3));
    hazard_ctrl_unit #(.STALL_CYCLES(4)) d4 (.clk(clk), .reset(reset),
        .stall_cnt(sc[2]), .flush_cnt(fc[2]), .hz(hz4));
`else
    hazard_ctrl_unit #(.STALL_CYCLES(1)) d1 (.clk(clk), .reset(reset), .hz(hz1));
    hazard_ctrl_unit #(.STALL_CYCLES(3)) d3 (.clk(clk), .reset(reset), .hz(hz3));
    hazard_ctrl_unit #(.STALL_CYCLES(4)) d4 (.clk(clk), .reset(reset), .hz(hz4));
`endif

    function automatic logic [6:0] pack(input logic p, i, b, f, s);
        return {p, i, b, f, f, f, s};
    endfunction

    // Reference: rem counts stall cycles still owed after the current one.
    function automatic logic [6:0] model(input int k, input logic haz);
        logic [6:0] o;
        logic       act;
        act = (rem[k] > 0);
        if (reset) begin
            o = 7'b0;
            rem[k] = 0;
        end else if (br) begin
            o = pack(1, 1, 0, 1, act);
            rem[k] = 0;
        end else if (rem[k] > 0) begin
            o = pack(0, 0, 1, 0, act);
            rem[k] = rem[k] - 1;
        end else if (haz) begin
            o = pack(0, 0, 1, 0, act);
            rem[k] = scyc[k] - 1;
        end else begin
            o = pack(1, 1, 0, 0, act);
        end
        return o;
    endfunction

    task automatic step(input logic m, input int d, r1, r2,
                        input logic u, b, rs, input string tag);
        exp_t x;
        logic haz;
        @(posedge clk);
        #1;
        reset = rs; memread = m; uses2 = u; br = b;
        rd = 5'(d); rs1 = 5'(r1); rs2 = 5'(r2);
        haz = m && (d != 0) && ((d == r1) || (u && d == r2));
        x.tag = tag;
        for (int k = 0; k < 3; k++) begin
            x.e[k] = model(k, haz);
`ifdef HAZ_PERF_CNT_EN
            if (rs) begin
                msc[k] = 0; mfc[k] = 0;
            end else begin
                if (!x.e[k][6]) msc[k] = msc[k] + 1;
                if (b) mfc[k] = mfc[k] + 1;
            end
`endif
        end
        q.push_back(x);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    function automatic logic [6:0] got(input int k);
        case (k)
            0: return {hz1.pc_write, hz1.ifid_write, hz1.idex_bubble,
                       hz1.ifid_flush, hz1.idex_flush, hz1.exmem_flush,
                       hz1.stall_active};
            1: return {hz3.pc_write, hz3.ifid_write, hz3.idex_bubble,
                       hz3.ifid_flush, hz3.idex_flush, hz3.exmem_flush,
                       hz3.stall_active};
            default: return {hz4.pc_write, hz4.ifid_write, hz4.idex_bubble,
                       hz4.ifid_flush, hz4.idex_flush, hz4.exmem_flush,
                       hz4.stall_active};
        endcase
    endfunction

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got(k) !== x.e[k]) begin
                    errors++;
                    $display("FAIL %s S=%0d: got %b expected %b (pc,ifw,bub,fl3,sa)",
                             x.tag, scyc[k], got(k), x.e[k]);
                end
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 0, 0, 1, "reset");
        idle(2, "run");
        step(1, 5, 5, 0, 0, 0, 0, "lu_rs1");
        idle(5, "after_rs1");
        step(1, 7, 1, 7, 1, 0, 0, "lu_rs2");
        idle(5, "after_rs2");
        step(1, 7, 1, 7, 0, 0, 0, "no_rs2");
        step(1, 0, 0, 0, 1, 0, 0, "x0");
        idle(2, "after_x0");
        step(1, 9, 9, 0, 0, 0, 0, "br_mid_hz");
        step(0, 0, 0, 0, 0, 1, 0, "br_mid");
        idle(4, "after_br");
        step(1, 9, 9, 0, 0, 1, 0, "hz_and_br");
        idle(4, "after_hzbr");
        step(1, 3, 3, 0, 0, 0, 0, "rst_mid_hz");
        step(0, 0, 0, 0, 0, 0, 1, "rst_mid");
        step(0, 0, 0, 0, 0, 0, 0, "rst_rel");
        idle(3, "after_rst");
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 "rand");
        end
        idle(2, "tail");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
`ifdef HAZ_PERF_CNT_EN
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks += 2;
            if (sc[k] !== msc[k]) begin
                errors++;
                $display("FAIL stall_cnt S=%0d: got %0d expected %0d",
                         scyc[k], sc[k], msc[k]);
            end
            if (fc[k] !== mfc[k]) begin
                errors++;
                $display("FAIL flush_cnt S=%0d: got %0d expected %0d",
                         scyc[k], fc[k], mfc[k]);
            end
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Consumer-side controller for the ID/EX pipeline register. It watches the ID/EX load destination against the IF/ID source registers and resolves the branch outcome from EX/MEM. It drives the stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. A small FSM with a countdown extends load-use stalls for multi-cycle data memory.

Parameters:
REG_AW, 5, register-index width
STALL_CYCLES, 1, total stall cycles per load-use hazard (1..15)
CNT_W, 4, stall-counter width (must hold STALL_CYCLES-1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
idex_memread  in  1  ID/EX holds a load
idex_rd  in  REG_AW  ID/EX destination register
ifid_rs1  in  REG_AW  IF/ID source 1
ifid_rs2  in  REG_AW  IF/ID source 2
ifid_uses_rs2  in  1  IF/ID instruction reads rs2 (R/S/B-type)
branch_taken  in  1  EX/MEM branch or jal resolved taken (1-cycle pulse)
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_bubble  out  1  zero all ID/EX control inputs this cycle
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX
exmem_flush  out  1  clear EX/MEM control
stall_active  out  1  registered: FSM in LU_STALL

Behaviour:
- lu_hazard = idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & idex_rd == ifid_rs2)). Combinational, same-cycle.
- FSM states: RUN, LU_STALL. State and cnt[CNT_W-1:0] are registered. All outputs except stall_active are combinational from state, cnt and inputs.
- RUN, no event: pc_write=1, ifid_write=1, all other outputs 0.
- RUN with lu_hazard and no branch_taken:
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - If STALL_CYCLES>1: next state LU_STALL, cnt <= STALL_CYCLES-1. Otherwise remain in RUN.
- LU_STALL: pc_write=0, ifid_write=0, idex_bubble=1. cnt decrements each clock. When cnt==1 at the clock edge, next state is RUN.
- Total stall therefore equals exactly STALL_CYCLES cycles. lu_hazard is ignored inside LU_STALL.
- branch_taken in any state has top priority:
  - ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1 (target loads), ifid_write=1, idex_bubble=0.
  - Next state is RUN and cnt is cleared. A pending stall is squashed with its instruction.
- Simultaneous lu_hazard and branch_taken: the branch wins, with no stall.
- stall_active = (state==LU_STALL), registered.
- Reset (asynchronous, takes effect at any point including mid-stall):
  - state=RUN, cnt=0, stall_active=0.
  - While reset is high, combinational outputs are forced to pc_write=0, ifid_write=0, idex_bubble=0, all flushes 0.
- Release of reset returns directly to normal RUN behaviour on the next cycle.
- x0 destination never causes a stall.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both saturating at 32'hFFFF_FFFF and cleared by reset.
  - stall_cnt increments on every cycle with pc_write=0 and reset low.
  - flush_cnt increments on every cycle with branch_taken=1.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - state enum (RUN, LU_STALL)
  - REG_AW default constant
  - X0 index constant
  - perf counter width constant (32)
- Sub-module lu_hazard_detect: purely combinational comparator producing lu_hazard. It is reused by the forwarding checks.
- FSM, counter and output decode stay in the top module.

Test Plan:
1. STALL_CYCLES=1; idex_memread=1, idex_rd=5, ifid_rs1=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_active stays 0.
2. STALL_CYCLES=3; hazard on rs2=7 with ifid_uses_rs2=1 -> 3 consecutive stall cycles, stall_active=1 on cycles 2-3, then RUN; repeat with ifid_uses_rs2=0 -> no stall.
3. idex_rd=0, ifid_rs1=0, idex_memread=1 -> no stall; pc_write=1 throughout.
4. STALL_CYCLES=3; branch_taken pulsed in the second stall cycle -> same cycle all three flushes=1, pc_write=1, idex_bubble=0; next cycle state RUN, stall_active=0.
5. Hazard and branch_taken in the same cycle -> flush outputs only, no stall cycles follow.
6. reset asserted mid-LU_STALL (STALL_CYCLES=4, cycle 2) -> immediately pc_write=0, all flushes 0, stall_active=0; after release pc_write=1 with no residual stall. With HAZ_PERF_CNT_EN, both counters read 0.
